// File: rtl/axi_defs_pkg.sv
// Shared AXI encodings and FSM state types for the memory slave.
package axi_defs_pkg;

    // Burst type encodings.
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    // Response encodings; numeric order matches severity (DECERR worst).
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Only full 32-bit beats are served.
    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    // Worse of two responses; relies on OKAY < SLVERR < DECERR numerically.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address generator for FIXED/INCR/WRAP bursts.
module axi_burst_addr
    import axi_defs_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap_ok
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] win_mask;

    // WRAP keeps the upper bits of the aligned window and wraps the offset.
    always_comb begin
        step      = ADDR_W'(1) << size;
        incr_addr = addr + step;
        win_mask  = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = wrap_ok ? ((addr & ~win_mask) | (incr_addr & win_mask))
                                            : incr_addr;
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent single-outstanding write and read FSMs
// over a word-addressed memory, with registered, pre-fetched read data.
module axi_mem_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_WORDS        = 1024,
    parameter int C_RD_WAIT          = 2
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [1:0]                      dbg_wr_state,
    output logic [1:0]                      dbg_rd_state
);
    import axi_defs_pkg::*;

    // Handshake rule on every channel: a transfer happens on the rising edge
    // where VALID and READY are both high; VALID never waits on READY.

    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W  = $clog2(C_MEM_WORDS);
    localparam logic [AW-1:0] MEM_WORDS = AW'(C_MEM_WORDS);
    localparam logic [15:0]   WAIT_LAST = 16'(C_RD_WAIT - 1);

    logic [DW-1:0] mem [C_MEM_WORDS];

    // ---------------- write path ----------------
    wr_state_t                   wr_state, wr_next;
    logic [C_S_AXI_ID_WIDTH-1:0] aw_id_q;
    logic [AW-1:0]               aw_addr_q, w_next_addr;
    logic [7:0]                  aw_len_q, w_cnt;
    logic [2:0]                  aw_size_q;
    logic [1:0]                  aw_burst_q, w_acc, w_beat_resp, w_beat_worst;
    logic                        w_wrap_ok, w_final, w_txn_err, w_fire;
    logic [IDX_W-1:0]            w_idx;

    axi_burst_addr #(.ADDR_W(AW)) u_wr_addr (
        .addr(aw_addr_q), .len(aw_len_q), .size(aw_size_q), .burst(aw_burst_q),
        .next_addr(w_next_addr), .wrap_ok(w_wrap_ok)
    );

    assign w_final      = (w_cnt == aw_len_q);
    assign w_txn_err    = (aw_size_q != SIZE_WORD) || (aw_burst_q == 2'd3) ||
                          ((aw_burst_q == BURST_WRAP) && !w_wrap_ok);
    assign w_beat_resp  = ((aw_addr_q >> 2) >= MEM_WORDS) ? RESP_DECERR :
                          w_txn_err ? RESP_SLVERR : RESP_OKAY;
    assign w_beat_worst = worst_resp(w_beat_resp, (S_AXI_WLAST != w_final) ? RESP_SLVERR : RESP_OKAY);
    assign w_fire       = (wr_state == W_DATA) && S_AXI_WVALID;
    assign w_idx        = aw_addr_q[IDX_W+1:2];
    assign dbg_wr_state = wr_state;

    // Write FSM next state and channel ready/valid outputs.
    always_comb begin
        wr_next       = wr_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                S_AXI_AWREADY = S_AXI_ARESETN;
                if (S_AXI_AWVALID && S_AXI_ARESETN) wr_next = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_final) wr_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Write state, request latch, beat counter and accumulated response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state    <= W_IDLE;
            aw_id_q     <= '0;
            aw_addr_q   <= '0;
            aw_len_q    <= '0;
            aw_size_q   <= '0;
            aw_burst_q  <= '0;
            w_cnt       <= '0;
            w_acc       <= RESP_OKAY;
            S_AXI_BRESP <= '0;
            S_AXI_BID   <= '0;
        end else begin
            wr_state <= wr_next;
            if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                aw_id_q    <= S_AXI_AWID;
                aw_addr_q  <= S_AXI_AWADDR;
                aw_len_q   <= S_AXI_AWLEN;
                aw_size_q  <= S_AXI_AWSIZE;
                aw_burst_q <= S_AXI_AWBURST;
                w_cnt      <= '0;
                w_acc      <= RESP_OKAY;
            end
            if (w_fire) begin
                aw_addr_q <= w_next_addr;
                w_cnt     <= w_cnt + 8'd1;
                w_acc     <= worst_resp(w_acc, w_beat_worst);
                if (w_final) begin
                    S_AXI_BRESP <= worst_resp(w_acc, w_beat_worst);
                    S_AXI_BID   <= aw_id_q;
                end
            end
        end
    end

    // Byte-enabled memory write; erroneous beats leave memory untouched.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_fire && (w_beat_resp == RESP_OKAY)) begin
            for (int b = 0; b < DW/8; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t                   rd_state, rd_next;
    logic [C_S_AXI_ID_WIDTH-1:0] ar_id_q;
    logic [AW-1:0]               ar_addr_q, eff_addr, r_next_addr, r_ld_addr;
    logic [7:0]                  ar_len_q, eff_len, r_cnt;
    logic [2:0]                  ar_size_q, eff_size;
    logic [1:0]                  ar_burst_q, eff_burst, r_ld_resp;
    logic [15:0]                 wait_cnt;
    logic                        r_wrap_ok, r_txn_err, r_ld, r_ld_last, r_in_idle;
    logic [IDX_W-1:0]            r_ld_idx;

    // In idle the request fields come straight from AR so a zero-wait read
    // can fetch its first beat on the handshake edge.
    assign r_in_idle = (rd_state == R_IDLE);
    assign eff_addr  = r_in_idle ? S_AXI_ARADDR  : ar_addr_q;
    assign eff_len   = r_in_idle ? S_AXI_ARLEN   : ar_len_q;
    assign eff_size  = r_in_idle ? S_AXI_ARSIZE  : ar_size_q;
    assign eff_burst = r_in_idle ? S_AXI_ARBURST : ar_burst_q;

    axi_burst_addr #(.ADDR_W(AW)) u_rd_addr (
        .addr(eff_addr), .len(eff_len), .size(eff_size), .burst(eff_burst),
        .next_addr(r_next_addr), .wrap_ok(r_wrap_ok)
    );

    assign r_txn_err    = (eff_size != SIZE_WORD) || (eff_burst == 2'd3) ||
                          ((eff_burst == BURST_WRAP) && !r_wrap_ok);
    assign r_ld_resp    = ((r_ld_addr >> 2) >= MEM_WORDS) ? RESP_DECERR :
                          r_txn_err ? RESP_SLVERR : RESP_OKAY;
    assign r_ld_idx     = r_ld_addr[IDX_W+1:2];
    assign dbg_rd_state = rd_state;

    // Read FSM next state, valid/ready outputs and pre-fetch load control.
    always_comb begin
        rd_next       = rd_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        r_ld          = 1'b0;
        r_ld_addr     = ar_addr_q;
        r_ld_last     = 1'b0;
        case (rd_state)
            R_IDLE: begin
                S_AXI_ARREADY = S_AXI_ARESETN;
                if (S_AXI_ARVALID && S_AXI_ARESETN) begin
                    rd_next = (C_RD_WAIT == 0) ? R_DATA : R_WAIT;
                    if (C_RD_WAIT == 0) begin
                        r_ld      = 1'b1;
                        r_ld_addr = S_AXI_ARADDR;
                        r_ld_last = (S_AXI_ARLEN == 8'd0);
                    end
                end
            end
            R_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    rd_next   = R_DATA;
                    r_ld      = 1'b1;
                    r_ld_last = (ar_len_q == 8'd0);
                end
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) begin
                    if (r_cnt == ar_len_q) begin
                        rd_next = R_IDLE;
                    end else begin
                        r_ld      = 1'b1;
                        r_ld_addr = r_next_addr;
                        r_ld_last = ((r_cnt + 8'd1) == ar_len_q);
                    end
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read state, request latch, counters and the registered R beat.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state    <= R_IDLE;
            ar_id_q     <= '0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            ar_size_q   <= '0;
            ar_burst_q  <= '0;
            r_cnt       <= '0;
            wait_cnt    <= '0;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= '0;
            S_AXI_RLAST <= 1'b0;
            S_AXI_RID   <= '0;
        end else begin
            rd_state <= rd_next;
            if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                ar_id_q    <= S_AXI_ARID;
                ar_addr_q  <= S_AXI_ARADDR;
                ar_len_q   <= S_AXI_ARLEN;
                ar_size_q  <= S_AXI_ARSIZE;
                ar_burst_q <= S_AXI_ARBURST;
                r_cnt      <= '0;
                wait_cnt   <= '0;
            end
            if (rd_state == R_WAIT) wait_cnt <= wait_cnt + 16'd1;
            if ((rd_state == R_DATA) && S_AXI_RREADY && (r_cnt != ar_len_q)) begin
                ar_addr_q <= r_next_addr;
                r_cnt     <= r_cnt + 8'd1;
            end
            if (r_ld) begin
                S_AXI_RDATA <= (r_ld_resp == RESP_OKAY) ? mem[r_ld_idx] : '0;
                S_AXI_RRESP <= r_ld_resp;
                S_AXI_RLAST <= r_ld_last;
                S_AXI_RID   <= r_in_idle ? S_AXI_ARID : ar_id_q;
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, wrap, strobes, errors, reset abort.
module tb_axi_mem_slave;

    localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2;

    logic        clk, rst_n;
    logic [0:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp, dbg_wr, dbg_rd;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  exp_resp_q[$];

    axi_mem_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .dbg_wr_state(dbg_wr), .dbg_rd_state(dbg_rd)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic id, input logic [31:0] base,
                             input logic [3:0] strb, input int last_at,
                             output logic [1:0] resp, output logic id_out);
        int t;
        awaddr = addr; awlen = len; awburst = burst; awsize = size; awid = id; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        check_eq("awready", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = base + 32'(i); wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            check_eq("wready", wready, 1'b1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        check_eq("bvalid", bvalid, 1'b1);
        resp = bresp; id_out = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Pops one expected data/resp pair per beat; throttle stalls every other cycle.
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic id, input bit throttle);
        int t, beat;
        bit stall, chk_hold;
        logic [31:0] hold;
        araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        check_eq("arready", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        beat = 0; t = 0; stall = throttle; chk_hold = 1'b0; hold = '0;
        while (beat <= int'(len) && t < 400) begin
            if (chk_hold) begin
                check_eq("rdata_stall", rdata, hold);
                chk_hold = 1'b0;
            end
            if (rvalid && stall) begin
                rready = 1'b0; hold = rdata; chk_hold = 1'b1; stall = 1'b0;
            end else if (rvalid) begin
                rready = 1'b1;
                check_eq("rdata", rdata, exp_q.pop_front());
                check_eq("rresp", rresp, exp_resp_q.pop_front());
                check_eq("rlast", rlast, beat == int'(len));
                check_eq("rid", rid, id);
                beat++;
                stall = throttle;
            end else begin
                rready = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        check_eq("r_beats", beat, int'(len) + 1);
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [1:0] r);
        exp_q.push_back(d);
        exp_resp_q.push_back(r);
    endtask

    logic [1:0]  resp;
    logic        id_o;
    logic [31:0] wrap_exp [8];
    int t;

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = INCR; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = INCR; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_awready", awready, 1'b0);
        check_eq("rst_arready", arready, 1'b0);
        check_eq("rst_bvalid", bvalid, 1'b0);
        check_eq("rst_rvalid", rvalid, 1'b0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_bresp", bresp, 2'd0);
        check_eq("rst_states", {dbg_wr, dbg_rd}, 4'h0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_awready", awready, 1'b1);
        check_eq("rel_arready", arready, 1'b1);
        @(negedge clk);

        // INCR write then read back.
        axi_write(32'h40, 8'd7, INCR, 3'd2, 1'b1, 32'h10, 4'hF, 7, resp, id_o);
        check_eq("incr_bresp", resp, 2'd0);
        check_eq("incr_bid", id_o, 1'b1);
        for (int i = 0; i < 8; i++) push_exp(32'h10 + 32'(i), 2'd0);
        axi_read(32'h40, 8'd7, INCR, 3'd2, 1'b1, 1'b0);

        // WRAP read starting mid-window.
        wrap_exp = '{32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h10, 32'h11, 32'h12};
        for (int i = 0; i < 8; i++) push_exp(wrap_exp[i], 2'd0);
        axi_read(32'h4C, 8'd7, WRAP, 3'd2, 1'b0, 1'b0);

        // Strobed single-byte write, throttled read.
        axi_write(32'h0, 8'd0, INCR, 3'd2, 1'b0, 32'h5A5A5A5A, 4'hF, 0, resp, id_o);
        axi_write(32'h40, 8'd0, INCR, 3'd2, 1'b0, 32'hAABBCCDD, 4'b0010, 0, resp, id_o);
        check_eq("strb_bresp", resp, 2'd0);
        push_exp(32'h0000CC10, 2'd0);
        for (int i = 1; i < 4; i++) push_exp(32'h10 + 32'(i), 2'd0);
        axi_read(32'h40, 8'd3, INCR, 3'd2, 1'b0, 1'b1);

        // FIXED read repeats one word.
        for (int i = 0; i < 3; i++) push_exp(32'h11, 2'd0);
        axi_read(32'h44, 8'd2, FIXED, 3'd2, 1'b0, 1'b0);

        // Out-of-range write: DECERR, aliased word 0 untouched; out-of-range read.
        axi_write(32'h1000, 8'd0, INCR, 3'd2, 1'b0, 32'hDEADBEEF, 4'hF, 0, resp, id_o);
        check_eq("decerr_bresp", resp, 2'd3);
        push_exp(32'h5A5A5A5A, 2'd0);
        axi_read(32'h0, 8'd0, INCR, 3'd2, 1'b0, 1'b0);
        push_exp(32'h0, 2'd3);
        axi_read(32'h1000, 8'd0, INCR, 3'd2, 1'b0, 1'b0);

        // Illegal size and illegal wrap length.
        for (int i = 0; i < 2; i++) push_exp(32'h0, 2'd2);
        axi_read(32'h40, 8'd1, INCR, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_exp(32'h0, 2'd2);
        axi_read(32'h40, 8'd2, WRAP, 3'd2, 1'b0, 1'b0);
        axi_write(32'h80, 8'd2, WRAP, 3'd2, 1'b0, 32'h77, 4'hF, 2, resp, id_o);
        check_eq("wrap2_bresp", resp, 2'd2);

        // Premature WLAST on the second beat of a 4-beat burst.
        axi_write(32'h100, 8'd3, INCR, 3'd2, 1'b0, 32'h30, 4'hF, 1, resp, id_o);
        check_eq("wlast_bresp", resp, 2'd2);

        // Same-word write lands on the edge that fetches the read beat.
        axi_write(32'hC0, 8'd0, INCR, 3'd2, 1'b0, 32'h11111111, 4'hF, 0, resp, id_o);
        awaddr = 32'hC0; awlen = 8'd0; awburst = INCR; awsize = 3'd2; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        araddr = 32'hC0; arlen = 8'd0; arburst = INCR; arsize = 3'd2; arid = 1'b0; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        check_eq("rd_wait_rvalid", rvalid, 1'b0);
        wdata = 32'h22222222; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
        check_eq("rd_wait_done", rvalid, 1'b1);
        check_eq("same_word_old", rdata, 32'h11111111);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        check_eq("same_word_bresp", {bvalid, bresp}, 3'b100);
        @(negedge clk);
        bready = 1'b0;
        push_exp(32'h22222222, 2'd0);
        axi_read(32'hC0, 8'd0, INCR, 3'd2, 1'b0, 1'b0);

        // Reset in the middle of an 8-beat write and an 8-beat read.
        araddr = 32'h40; arlen = 8'd7; arburst = INCR; arsize = 3'd2; arid = 1'b0; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 50) begin @(negedge clk); t++; end
        check_eq("abort_rvalid", rvalid, 1'b1);
        awaddr = 32'h200; awlen = 8'd7; awburst = INCR; awsize = 3'd2; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wrap_exp = '{32'h0000CC10, 32'h11, 32'h12, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            check_eq("abort_rdata", rdata, wrap_exp[i]);
            wdata = 32'hA0 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1; rready = 1'b1;
            @(negedge clk);
        end
        rready = 1'b0;
        wdata = 32'hA3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_rvalid_drop", rvalid, 1'b0);
        check_eq("abort_wready_drop", wready, 1'b0);
        check_eq("abort_awready", awready, 1'b0);
        check_eq("abort_rdata_clr", rdata, 32'h0);
        check_eq("abort_rlast_clr", rlast, 1'b0);
        wvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("abort_rel_awready", awready, 1'b1);
        check_eq("abort_rel_arready", arready, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_exp(32'hA0 + 32'(i), 2'd0);
        axi_read(32'h200, 8'd2, INCR, 3'd2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
